// File: rtl/aes_pkg.sv
// Shared AES definitions: round/width constants, FSM encoding, Rcon and the
// forward S-box so encryption and decryption stages use one table.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } exp_state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup of one byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for expansion step i (1..10); anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the forward S-box to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: expands one cipher key into 11 round keys, one per
// clock, and serves any stored round key by index with one-cycle latency.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic [3:0]       round_sel,
  output logic [KEY_W-1:0] round_key,
  output logic             key_ready,
  output logic             busy
);

  localparam logic [3:0] LAST = 4'(NR);

  exp_state_t       state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             busy_next, ready_next;
  logic [KEY_W-1:0] bank [0:NR];

  logic             bank_we;
  logic [3:0]       bank_widx;
  logic [KEY_W-1:0] bank_wdata;

  logic [KEY_W-1:0]  prev_key;
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w3, sub_w3, t;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  // Select the previous round key that feeds the current expansion step.
  always_comb begin
    prev_key = 128'h0;
    if ((cnt != 4'd0) && (cnt <= LAST)) begin
      prev_key = bank[cnt - 4'd1];
    end else begin
      prev_key = 128'h0;
    end
  end

  assign w0     = prev_key[127:96];
  assign w1     = prev_key[95:64];
  assign w2     = prev_key[63:32];
  assign w3     = prev_key[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  assign t  = sub_w3 ^ {rcon(cnt), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Next-state, counter, status flags and bank write request.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy_next  = busy;
    ready_next = key_ready;
    bank_we    = 1'b0;
    bank_widx  = 4'd0;
    bank_wdata = 128'h0;
    case (state)
      IDLE, READY: begin
        if (key_load) begin
          bank_we    = 1'b1;
          bank_widx  = 4'd0;
          bank_wdata = key_in;
          cnt_next   = 4'd1;
          busy_next  = 1'b1;
          ready_next = 1'b0;
          state_next = EXPAND;
        end else begin
          state_next = state;
        end
      end
      EXPAND: begin
        // Loads arriving here are deliberately dropped.
        bank_we    = 1'b1;
        bank_widx  = cnt;
        bank_wdata = {n0, n1, n2, n3};
        if (cnt == LAST) begin
          cnt_next   = 4'd0;
          busy_next  = 1'b0;
          ready_next = 1'b1;
          state_next = READY;
        end else begin
          cnt_next   = cnt + 4'd1;
        end
      end
      default: begin
        cnt_next   = 4'd0;
        busy_next  = 1'b0;
        ready_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Control registers: state, step counter and status outputs.
  always_ff @(posedge clk) begin
    if (rest) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      busy      <= busy_next;
      key_ready <= ready_next;
    end
  end

  // Round-key bank writes and the registered read port (old data on collision).
  always_ff @(posedge clk) begin
    if (rest) begin
      for (int k = 0; k <= NR; k++) begin
        bank[k] <= 128'h0;
      end
      round_key <= 128'h0;
    end else begin
      if (bank_we) begin
        bank[bank_widx] <= bank_wdata;
      end
      if (round_sel <= LAST) begin
        round_key <= bank[round_sel];
      end else begin
        round_key <= 128'h0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: table-driven reads through a
// scoreboard queue plus hand-written load/reset/reload sequences.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rest;
  logic [127:0] key_in;
  logic         key_load;
  logic [3:0]   round_sel;
  logic [127:0] round_key;
  logic         key_ready;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_q[$];

  typedef struct {
    logic [127:0] key;
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;

  vec_t vtab[$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] fips_rk [0:10];

  aes_key_expander #(.NR(10)) dut (
    .clk       (clk),
    .rest      (rest),
    .key_in    (key_in),
    .key_load  (key_load),
    .round_sel (round_sel),
    .round_key (round_key),
    .key_ready (key_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive round_sel for one edge, then pop the expected key and compare.
  task automatic step_read(input string name, input logic [3:0] sel, input logic [127:0] exp);
    logic [127:0] e;
    round_sel = sel;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, round_key, e);
  endtask

  // Pulse key_load across one edge; returns at the negedge after the accepting edge.
  task automatic load_start(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    key_in   = ~k;
  endtask

  // Count edges until key_ready, bounded; check the count.
  task automatic wait_ready(input string name, input int exp_n);
    int n = 0;
    while (!key_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 128'(n), 128'(exp_n));
    check({name, "_busy_done"}, {127'h0, busy}, 128'h0);
  endtask

  task automatic full_load(input string name, input logic [127:0] k);
    load_start(k);
    check({name, "_busy_start"}, {127'h0, busy}, 128'h1);
    check({name, "_ready_start"}, {127'h0, key_ready}, 128'h0);
    wait_ready(name, 10);
  endtask

  initial begin
    logic [127:0] cur_key;

    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Read sweep 10 -> 0 on the FIPS key, then out-of-range indices.
    for (int i = 10; i >= 0; i--) vtab.push_back('{FIPS_KEY, 4'(i), fips_rk[i]});
    vtab.push_back('{FIPS_KEY, 4'd15, 128'h0});
    vtab.push_back('{FIPS_KEY, 4'd11, 128'h0});
    vtab.push_back('{ZERO_KEY, 4'd1,  128'h62636363626363636263636362636363});
    vtab.push_back('{ZERO_KEY, 4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
    vtab.push_back('{ZERO_KEY, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
    vtab.push_back('{ZERO_KEY, 4'd0,  128'h0});

    rest      = 1'b1;
    key_in    = 128'h0;
    key_load  = 1'b0;
    round_sel = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_round_key", round_key, 128'h0);
    check("reset_ready", {127'h0, key_ready}, 128'h0);
    check("reset_busy", {127'h0, busy}, 128'h0);
    rest = 1'b0;
    @(negedge clk);

    // Table-driven reads; load a key whenever the record's key changes.
    cur_key = ~FIPS_KEY;
    foreach (vtab[i]) begin
      if (vtab[i].key !== cur_key) begin
        full_load("tab_load", vtab[i].key);
        cur_key = vtab[i].key;
      end
      step_read($sformatf("tab_%0d_sel%0d", i, vtab[i].sel), vtab[i].sel, vtab[i].exp);
    end

    // Ignored load during expansion: accepted at T, stray pulse sampled at T+4.
    load_start(FIPS_KEY);
    repeat (3) @(negedge clk);
    key_in   = ALT_KEY;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    check("ign_busy", {127'h0, busy}, 128'h1);
    wait_ready("ign", 6);
    step_read("ign_sel10", 4'd10, fips_rk[10]);
    step_read("ign_sel1", 4'd1, fips_rk[1]);
    step_read("ign_sel0", 4'd0, FIPS_KEY);

    // Reset mid-expansion at T+5.
    load_start(ZERO_KEY);
    repeat (4) @(negedge clk);
    rest = 1'b1;
    @(negedge clk);
    rest = 1'b0;
    check("rst_mid_busy", {127'h0, busy}, 128'h0);
    check("rst_mid_ready", {127'h0, key_ready}, 128'h0);
    check("rst_mid_round_key", round_key, 128'h0);
    step_read("rst_mid_sel3", 4'd3, 128'h0);
    step_read("rst_mid_sel0", 4'd0, 128'h0);
    full_load("after_rst", FIPS_KEY);
    step_read("after_rst_sel5", 4'd5, fips_rk[5]);

    // Reload from READY back-to-back: load issued as soon as key_ready reads 1.
    load_start(FIPS_KEY);
    wait_ready("reload_a", 10);
    load_start(ZERO_KEY);
    check("reload_ready_drop", {127'h0, key_ready}, 128'h0);
    check("reload_busy", {127'h0, busy}, 128'h1);
    wait_ready("reload_b", 10);
    step_read("reload_sel10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Read/write collision: sel 1 read at edge T+1 returns the previous key's round 1.
    round_sel = 4'd1;
    exp_q.push_back(128'h62636363626363636263636362636363);
    key_in   = FIPS_KEY;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    @(negedge clk);
    begin
      logic [127:0] e;
      e = exp_q.pop_front();
      check("collide_old", round_key, e);
    end
    step_read("collide_new", 4'd1, fips_rk[1]);
    wait_ready("collide", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Upstream key-schedule stage for the AES-128 datapath. It accepts one 128-bit cipher key and expands it iteratively, one round key per clock, into all 11 round keys. It stores them in a register bank and serves any round key by index with one-cycle read latency. The decryption round engine indexes it downward (10 → 0) and waits on `key_ready` before starting.

## Interface
- `NR`, default 10: number of AES rounds; the bank holds `NR+1` keys. Only 10 (AES-128) is supported.
- `clk` in 1: single clock; all logic on the rising edge.
- `rest` in 1: reset. **Synchronous, active-high.**
- `key_in` in 128: cipher key. Bits [127:96] are word w0.
- `key_load` in 1: single-cycle request to expand `key_in`.
- `round_sel` in 4: index (0..10) of the round key to read.
- `round_key` out 128: registered round key for `round_sel` sampled at the previous edge.
- `key_ready` out 1: level. All 11 keys are valid for the current key.
- `busy` out 1: level. Expansion is in progress.

## Operation
- States: `IDLE` (no valid key), `EXPAND`, `READY`.
- **Reset** (`rest`=1 at an edge):
  - state → `IDLE`, round counter → 0.
  - `round_key`=0, `key_ready`=0, `busy`=0.
  - All 11 bank entries cleared to 0.
  - Reset overrides everything, including mid-expansion.
- **Accepting a load:**
  - In `IDLE` or `READY`, `key_load`=1 is accepted.
  - At that edge: `bank[0]` ← `key_in`, counter ← 1, `busy` ← 1, `key_ready` ← 0, state → `EXPAND`.
- **Expansion step** (state `EXPAND`, counter i = 1..10), one round key per edge:
  - Split the previous key `bank[i-1]` into words w0..w3.
  - t = SubWord(RotWord(w3)) ^ {Rcon[i], 24'h0}, where RotWord rotates bytes left by one.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - `bank[i]` ← {n0,n1,n2,n3}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- **Completion:** at the edge that writes `bank[10]`: `busy` ← 0, `key_ready` ← 1, state → `READY`.
- **Read port:** every edge (including during `EXPAND`), `round_key` ← `bank[round_sel]`.
  - `round_sel` > 10 gives 0.
  - During `EXPAND`, entries not yet written hold old contents. Consumers must not use them.
- **Boundary conditions:**
  - `key_load` during `EXPAND` is ignored and does not restart expansion.
  - `key_load` in `READY` restarts expansion; `key_ready` drops at that same edge.
  - `key_in` is sampled only at the accepting edge; later changes have no effect.
  - A read and a write to the same index at one edge return the old contents.

## Timing
- Accepting `key_load` at edge T gives `busy`=1 after T.
- Edges T+1..T+10 write keys 1..10.
- After edge T+10: `key_ready`=1, `busy`=0. Load-to-ready latency is 10 cycles.
- Read latency is 1 cycle. `round_sel` is applied before edge E, and `round_key` is valid after E.
- This matches a consumer that sets the round number in one state and uses the key in the next.
- Back-to-back: a `key_load` in the cycle where `key_ready` first reads 1 is accepted.

## Structure
- Shared package `aes_pkg`:
  - Rcon table.
  - State encoding constants (`IDLE`/`EXPAND`/`READY`).
  - `NR`, word/key width constants.
  - S-box table, so the decryption side uses the same definition.
- One sub-module `aes_sub_word`: combinational, 32-bit in/out, four forward S-box lookups.
- FSM, counter, bank, and XOR chain stay in the top module.

## Test plan
- **FIPS-197 key:** reset, then `key_load` with 2b7e151628aed2a6abf7158809cf4f3c.
  - Expect `key_ready` after exactly 10 cycles.
  - `round_sel`=1 → a0fafe1788542cb123a339392a6c7605.
  - `round_sel`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `round_sel`=0 → the original key.
- **All-zero key:**
  - `round_sel`=1 → 62636363626363636263636362636363.
  - `round_sel`=10 → b4ef5bcb3e92e21123e951cf6f8f188e.
- **Ignored load:** pulse `key_load` with a different key at cycle T+4 of an expansion.
  - It is ignored; results equal the first key's schedule.
  - `key_ready` still rises after T+10.
- **Reset mid-expansion:** assert `rest` at T+5.
  - Next cycle: `busy`=0, `key_ready`=0, `round_key`=0.
  - `round_sel`=3 reads 0.
  - A new load completes normally.
- **Reload from `READY`:** load the FIPS key, then load the zero key.
  - `key_ready` falls at the accepting edge and rises 10 cycles later.
  - Round 10 reads b4ef5bcb3e92e21123e951cf6f8f188e.
- **Read sweep:** sweep `round_sel` 10→0, one per cycle.
  - Each key appears exactly one cycle after its index.
  - `round_sel`=15 → 0.
